// File: rtl/multi_alarm_controller.sv
// multi_alarm_controller: NUM_ALARMS independent daily alarms with snooze and ring
// timeout, merged into one registered buzzer plus per-channel status.
module multi_alarm_controller #(
   parameter int NUM_ALARMS       = 4,
   parameter int IDX_W            = 2,
   parameter int SNOOZE_SEC       = 5,
   parameter int RING_TIMEOUT_SEC = 60,
   parameter int MAX_SNOOZES      = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    tick,
   input  logic [7:0]              cur_hour,
   input  logic [7:0]              cur_min,
   input  logic [7:0]              cur_sec,
   input  logic                    set_alarm,
   input  logic [IDX_W-1:0]        set_idx,
   input  logic [7:0]              set_hour,
   input  logic [7:0]              set_min,
   input  logic [7:0]              set_sec,
   input  logic                    set_enable,
   input  logic                    snooze,
   input  logic                    stop,
   output logic                    alarm_buzzer,
   output logic [NUM_ALARMS-1:0]   ringing,
   output logic [NUM_ALARMS-1:0]   armed,
   output logic [IDX_W-1:0]        active_idx,
   output logic                    set_err,
   output logic [2*NUM_ALARMS-1:0] dbg_state
);

   localparam int SC_W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;

   typedef enum logic [1:0] {
      ST_DISABLED = 2'd0,
      ST_ARMED    = 2'd1,
      ST_RINGING  = 2'd2,
      ST_SNOOZED  = 2'd3
   } state_e;

   // Reset asserts asynchronously but releases only after two clean clock edges.
   logic [1:0] rst_sync_q;
   logic [1:0] rst_sync_d;
   logic       rst_n;

   assign rst_sync_d = {rst_sync_q[0], 1'b1};
   assign rst_n      = rst_sync_q[1];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= rst_sync_d;
      end
   end

   state_e              state_q    [NUM_ALARMS];
   state_e              state_d    [NUM_ALARMS];
   logic [7:0]          hour_q     [NUM_ALARMS];
   logic [7:0]          hour_d     [NUM_ALARMS];
   logic [7:0]          min_q      [NUM_ALARMS];
   logic [7:0]          min_d      [NUM_ALARMS];
   logic [7:0]          sec_q      [NUM_ALARMS];
   logic [7:0]          sec_d      [NUM_ALARMS];
   logic [7:0]          ring_cnt_q [NUM_ALARMS];
   logic [7:0]          ring_cnt_d [NUM_ALARMS];
   logic [7:0]          snz_cnt_q  [NUM_ALARMS];
   logic [7:0]          snz_cnt_d  [NUM_ALARMS];
   logic [SC_W-1:0]     snz_num_q  [NUM_ALARMS];
   logic [SC_W-1:0]     snz_num_d  [NUM_ALARMS];

   logic                  buzzer_q,     buzzer_d;
   logic [NUM_ALARMS-1:0] ringing_q,    ringing_d;
   logic [NUM_ALARMS-1:0] armed_q,      armed_d;
   logic [IDX_W-1:0]      active_idx_q, active_idx_d;
   logic                  set_err_q,    set_err_d;
   logic                  load_ok;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Load strobe: set_alarm is sampled on every edge with no back-pressure; an
   // illegal time or channel index is dropped and answered by a one-cycle set_err.
   always_comb begin
      load_ok = set_alarm && (set_hour <= 8'd23) && (set_min <= 8'd59) &&
                (set_sec <= 8'd59) && (32'(set_idx) < NUM_ALARMS);
      set_err_d  = set_alarm && !load_ok;
      state_d    = state_q;
      hour_d     = hour_q;
      min_d      = min_q;
      sec_d      = sec_q;
      ring_cnt_d = ring_cnt_q;
      snz_cnt_d  = snz_cnt_q;
      snz_num_d  = snz_num_q;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         if (load_ok && (32'(set_idx) == k)) begin
            hour_d[k]     = set_hour;
            min_d[k]      = set_min;
            sec_d[k]      = set_sec;
            state_d[k]    = set_enable ? ST_ARMED : ST_DISABLED;
            ring_cnt_d[k] = '0;
            snz_cnt_d[k]  = '0;
            snz_num_d[k]  = '0;
         end else begin
            case (state_q[k])
               ST_ARMED: begin
                  if (tick && (cur_hour == hour_q[k]) && (cur_min == min_q[k]) &&
                      (cur_sec == sec_q[k])) begin
                     state_d[k]    = ST_RINGING;
                     ring_cnt_d[k] = '0;
                     snz_num_d[k]  = '0;
                  end
               end
               ST_RINGING: begin
                  if (stop) begin
                     state_d[k] = ST_ARMED;
                  end else if (snooze) begin
                     if (32'(snz_num_q[k]) < MAX_SNOOZES) begin
                        state_d[k]   = ST_SNOOZED;
                        snz_cnt_d[k] = 8'(SNOOZE_SEC);
                        snz_num_d[k] = snz_num_q[k] + SC_W'(1);
                     end else begin
                        state_d[k] = ST_ARMED;
                     end
                  end else if (tick) begin
                     ring_cnt_d[k] = sat_inc(ring_cnt_q[k]);
                     if (sat_inc(ring_cnt_q[k]) >= 8'(RING_TIMEOUT_SEC)) begin
                        state_d[k] = ST_ARMED;
                     end
                  end
               end
               ST_SNOOZED: begin
                  if (stop) begin
                     state_d[k] = ST_ARMED;
                  end else if (tick) begin
                     if (snz_cnt_q[k] <= 8'd1) begin
                        state_d[k]    = ST_RINGING;
                        snz_cnt_d[k]  = '0;
                        ring_cnt_d[k] = '0;
                     end else begin
                        snz_cnt_d[k] = snz_cnt_q[k] - 8'd1;
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Status is decoded from the next state so the registered outputs line up with it.
   always_comb begin
      ringing_d    = '0;
      armed_d      = '0;
      active_idx_d = '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         ringing_d[k] = (state_d[k] == ST_RINGING);
         armed_d[k]   = (state_d[k] != ST_DISABLED);
      end
      for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
         if (ringing_d[k]) begin
            active_idx_d = IDX_W'(k);
         end
      end
      buzzer_d = |ringing_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_ALARMS; k++) begin
            state_q[k]    <= ST_DISABLED;
            hour_q[k]     <= '0;
            min_q[k]      <= '0;
            sec_q[k]      <= '0;
            ring_cnt_q[k] <= '0;
            snz_cnt_q[k]  <= '0;
            snz_num_q[k]  <= '0;
         end
         buzzer_q     <= 1'b0;
         ringing_q    <= '0;
         armed_q      <= '0;
         active_idx_q <= '0;
         set_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         hour_q       <= hour_d;
         min_q        <= min_d;
         sec_q        <= sec_d;
         ring_cnt_q   <= ring_cnt_d;
         snz_cnt_q    <= snz_cnt_d;
         snz_num_q    <= snz_num_d;
         buzzer_q     <= buzzer_d;
         ringing_q    <= ringing_d;
         armed_q      <= armed_d;
         active_idx_q <= active_idx_d;
         set_err_q    <= set_err_d;
      end
   end

   always_comb begin
      dbg_state = '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
         dbg_state[2*k +: 2] = state_q[k];
      end
   end

   assign alarm_buzzer = buzzer_q;
   assign ringing      = ringing_q;
   assign armed        = armed_q;
   assign active_idx   = active_idx_q;
   assign set_err      = set_err_q;

endmodule

// File: tb/tb_multi_alarm_controller.sv
// Bench for multi_alarm_controller: vector table for loads/triggers, then
// hand-written sequences for rollover, snooze, timeout and async reset.
module tb_multi_alarm_controller;

   localparam int N  = 4;
   localparam int IW = 3;

   logic         clk;
   logic         reset;
   logic         tick;
   logic [7:0]   cur_hour, cur_min, cur_sec;
   logic         set_alarm;
   logic [IW-1:0] set_idx;
   logic [7:0]   set_hour, set_min, set_sec;
   logic         set_enable, snooze, stop;
   logic         alarm_buzzer;
   logic [N-1:0] ringing, armed;
   logic [IW-1:0] active_idx;
   logic         set_err;
   logic [2*N-1:0] dbg_state;

   multi_alarm_controller #(
      .NUM_ALARMS(N), .IDX_W(IW), .SNOOZE_SEC(5), .RING_TIMEOUT_SEC(60), .MAX_SNOOZES(3)
   ) dut (
      .clk(clk), .reset(reset), .tick(tick),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .set_alarm(set_alarm), .set_idx(set_idx),
      .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
      .set_enable(set_enable), .snooze(snooze), .stop(stop),
      .alarm_buzzer(alarm_buzzer), .ringing(ringing), .armed(armed),
      .active_idx(active_idx), .set_err(set_err), .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- scoreboard ----------------
   int total = 0;
   int bad   = 0;
   logic [12:0] exp_q[$];
   string       name_q[$];

   function automatic logic [12:0] mk(logic b, logic [3:0] r, logic [3:0] a,
                                      logic [2:0] i, logic e);
      return {b, r, a, i, e};
   endfunction

   task automatic compare(input string nm, input logic [12:0] exp);
      logic [12:0] got;
      got = {alarm_buzzer, ringing, armed, active_idx, set_err};
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got buz=%b ring=%b armed=%b idx=%0d err=%b, want buz=%b ring=%b armed=%b idx=%0d err=%b",
                  nm, got[12], got[11:8], got[7:4], got[3:1], got[0],
                  exp[12], exp[11:8], exp[7:4], exp[3:1], exp[0]);
      end
   endtask

   task automatic check_state(input string nm, input int ch, input logic [1:0] exp);
      total++;
      if (dbg_state[2*ch +: 2] !== exp) begin
         bad++;
         $display("FAIL %s: ch%0d state got %0d want %0d", nm, ch, dbg_state[2*ch +: 2], exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle();
      set_alarm = 1'b0; tick = 1'b0; snooze = 1'b0; stop = 1'b0;
   endtask

   task automatic drv_load(input logic [2:0] idx, input logic [7:0] h, m, s, input logic en);
      set_alarm = 1'b1; set_idx = idx; set_hour = h; set_min = m; set_sec = s; set_enable = en;
   endtask

   task automatic drv_tick(input logic [7:0] h, m, s);
      tick = 1'b1; cur_hour = h; cur_min = m; cur_sec = s;
   endtask

   // Expected result is queued with the stimulus and retired after the edge.
   task automatic cycle(input string nm, input logic [12:0] exp);
      exp_q.push_back(exp);
      name_q.push_back(nm);
      @(posedge clk);
      #1;
      compare(name_q.pop_front(), exp_q.pop_front());
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       ld;
      logic [2:0] idx;
      logic [7:0] h, m, s;
      logic       en;
      logic       tk;
      logic [7:0] ch, cm, cs;
      logic       snz, stp;
      logic [12:0] exp;
   } vec_t;

   localparam int NV = 27;
   vec_t vecs[NV];

   function automatic vec_t v(logic ld, logic [2:0] idx, logic [7:0] h, m, s, logic en,
                              logic tk, logic [7:0] ch, cm, cs, logic snz, stp,
                              logic [12:0] exp);
      vec_t r;
      r.ld = ld; r.idx = idx; r.h = h; r.m = m; r.s = s; r.en = en;
      r.tk = tk; r.ch = ch; r.cm = cm; r.cs = cs; r.snz = snz; r.stp = stp; r.exp = exp;
      return r;
   endfunction

   logic [12:0] quiet, ring1;
   int abs_s;

   initial begin
      reset = 1'b1; idle(); set_idx = '0; set_hour = '0; set_min = '0; set_sec = '0;
      set_enable = 1'b0; cur_hour = 8'd0; cur_min = 8'd0; cur_sec = 8'd0;
      #1 reset = 1'b0;

      vecs[0]  = v(1,0,12,0,0,1,  0,0,0,0,      0,0, mk(0,4'b0000,4'b0001,0,0));
      vecs[1]  = v(1,2,12,0,0,1,  0,0,0,0,      0,0, mk(0,4'b0000,4'b0101,0,0));
      vecs[2]  = v(1,3,24,0,0,1,  0,0,0,0,      0,0, mk(0,4'b0000,4'b0101,0,1));
      vecs[3]  = v(1,4,10,0,0,1,  0,0,0,0,      0,0, mk(0,4'b0000,4'b0101,0,1));
      vecs[4]  = v(1,3,10,60,0,1, 0,0,0,0,      0,0, mk(0,4'b0000,4'b0101,0,1));
      vecs[5]  = v(1,3,10,0,60,1, 0,0,0,0,      0,0, mk(0,4'b0000,4'b0101,0,1));
      vecs[6]  = v(0,0,0,0,0,0,   0,0,0,0,      0,0, mk(0,4'b0000,4'b0101,0,0));
      vecs[7]  = v(1,3,10,0,59,1, 0,0,0,0,      0,0, mk(0,4'b0000,4'b1101,0,0));
      vecs[8]  = v(1,3,11,11,11,1,1,10,0,59,    0,0, mk(0,4'b0000,4'b1101,0,0));
      vecs[9]  = v(0,0,0,0,0,0,   1,10,0,59,    0,0, mk(0,4'b0000,4'b1101,0,0));
      vecs[10] = v(0,0,0,0,0,0,   1,11,11,11,   0,0, mk(1,4'b1000,4'b1101,3,0));
      vecs[11] = v(0,0,0,0,0,0,   0,0,0,0,      0,1, mk(0,4'b0000,4'b1101,0,0));
      vecs[12] = v(1,3,0,0,0,0,   0,0,0,0,      0,0, mk(0,4'b0000,4'b0101,0,0));
      vecs[13] = v(0,0,0,0,0,0,   1,12,0,0,     0,0, mk(1,4'b0101,4'b0101,0,0));
      vecs[14] = v(0,0,0,0,0,0,   1,12,0,1,     0,0, mk(1,4'b0101,4'b0101,0,0));
      vecs[15] = v(0,0,0,0,0,0,   0,0,0,0,      0,1, mk(0,4'b0000,4'b0101,0,0));
      vecs[16] = v(0,0,0,0,0,0,   1,12,0,0,     0,0, mk(1,4'b0101,4'b0101,0,0));
      vecs[17] = v(1,0,1,0,0,1,   0,0,0,0,      0,1, mk(0,4'b0000,4'b0101,0,0));
      vecs[18] = v(0,0,0,0,0,0,   1,12,0,0,     0,0, mk(1,4'b0100,4'b0101,2,0));
      vecs[19] = v(0,0,0,0,0,0,   0,0,0,0,      0,1, mk(0,4'b0000,4'b0101,0,0));
      vecs[20] = v(0,0,0,0,0,0,   1,12,0,0,     0,0, mk(1,4'b0100,4'b0101,2,0));
      vecs[21] = v(1,2,12,30,0,1, 0,0,0,0,      0,0, mk(0,4'b0000,4'b0101,0,0));
      vecs[22] = v(0,0,0,0,0,0,   1,12,30,1,    1,0, mk(0,4'b0000,4'b0101,0,0));
      vecs[23] = v(1,1,0,0,0,0,   0,0,0,0,      0,0, mk(0,4'b0000,4'b0101,0,0));
      vecs[24] = v(0,0,0,0,0,0,   1,12,30,0,    0,0, mk(1,4'b0100,4'b0101,2,0));
      vecs[25] = v(1,2,25,0,0,1,  0,0,0,0,      0,0, mk(1,4'b0100,4'b0101,2,1));
      vecs[26] = v(0,0,0,0,0,0,   0,0,0,0,      0,1, mk(0,4'b0000,4'b0101,0,0));

      // Reset held, then released; the synchronizer needs two edges.
      repeat (3) @(posedge clk);
      #1;
      compare("reset_held", mk(0,0,0,0,0));
      reset = 1'b1;
      for (int i = 0; i < 3; i++) cycle("reset_release", mk(0,0,0,0,0));

      for (int i = 0; i < NV; i++) begin
         set_alarm = vecs[i].ld; set_idx = vecs[i].idx;
         set_hour = vecs[i].h; set_min = vecs[i].m; set_sec = vecs[i].s;
         set_enable = vecs[i].en; tick = vecs[i].tk;
         cur_hour = vecs[i].ch; cur_min = vecs[i].cm; cur_sec = vecs[i].cs;
         snooze = vecs[i].snz; stop = vecs[i].stp;
         cycle($sformatf("vec%0d", i), vecs[i].exp);
      end
      idle();

      quiet = mk(0, 4'b0000, 4'b0111, 0, 0);
      ring1 = mk(1, 4'b0010, 4'b0111, 1, 0);

      // Midnight rollover: ch1 at 00:00:04, clock runs 23:59:57 .. 00:00:04.
      drv_load(1, 0, 0, 4, 1);
      cycle("load_ch1", quiet);
      idle();
      for (int i = 0; i < 8; i++) begin
         abs_s = (86397 + i) % 86400;
         drv_tick(8'(abs_s / 3600), 8'((abs_s / 60) % 60), 8'(abs_s % 60));
         cycle($sformatf("rollover_tick%0d", i), (i == 7) ? ring1 : quiet);
         idle();
         cycle($sformatf("rollover_gap%0d", i), (i == 7) ? ring1 : quiet);
      end

      // Three snoozes of five ticks each; snooze held through the 2nd countdown.
      for (int n = 1; n <= 3; n++) begin
         snooze = 1'b1;
         cycle($sformatf("snooze%0d", n), quiet);
         check_state($sformatf("snooze%0d_state", n), 1, 2'd3);
         for (int t = 1; t <= 5; t++) begin
            snooze = (n == 2) && (t < 5);
            drv_tick(2, 0, 0);
            cycle($sformatf("snz%0d_tick%0d", n, t), (t == 5) ? ring1 : quiet);
            tick = 1'b0;
            cycle($sformatf("snz%0d_gap%0d", n, t), (t == 5) ? ring1 : quiet);
         end
         idle();
      end
      snooze = 1'b1;
      cycle("snooze4_stops", quiet);
      check_state("snooze4_state", 1, 2'd1);
      idle();
      for (int t = 0; t < 6; t++) begin
         drv_tick(2, 0, 0);
         cycle("after_snooze4", quiet);
         idle();
      end

      // Stop while SNOOZED returns to ARMED and no re-ring follows.
      drv_tick(0, 0, 4);
      cycle("ring_again", ring1);
      idle();
      snooze = 1'b1;
      cycle("snooze_then_stop", quiet);
      idle();
      stop = 1'b1;
      cycle("stop_in_snoozed", quiet);
      check_state("stop_in_snoozed_state", 1, 2'd1);
      idle();
      for (int t = 0; t < 6; t++) begin
         drv_tick(2, 0, 0);
         cycle("no_rering", quiet);
         idle();
      end

      // Unattended ring times out after 60 ticks.
      drv_tick(0, 0, 4);
      cycle("timeout_start", ring1);
      idle();
      for (int i = 1; i <= 60; i++) begin
         drv_tick(6, 0, 0);
         cycle($sformatf("timeout_tick%0d", i), (i == 60) ? quiet : ring1);
         idle();
         cycle($sformatf("timeout_gap%0d", i), (i == 60) ? quiet : ring1);
      end

      // Async reset while ch0 rings; nothing rings after release until reloaded.
      drv_tick(1, 0, 0);
      cycle("ch0_ring", mk(1, 4'b0001, 4'b0111, 0, 0));
      idle();
      #3 reset = 1'b0;
      #1 compare("reset_async", mk(0,0,0,0,0));
      cycle("reset_low", mk(0,0,0,0,0));
      reset = 1'b1;
      for (int i = 0; i < 3; i++) cycle("reset_release2", mk(0,0,0,0,0));
      drv_tick(1, 0, 0);
      cycle("no_ring_after_reset", mk(0,0,0,0,0));
      idle();
      drv_load(0, 1, 0, 0, 1);
      cycle("reload_ch0", mk(0, 4'b0000, 4'b0001, 0, 0));
      idle();
      drv_tick(1, 0, 0);
      cycle("ring_after_reload", mk(1, 4'b0001, 4'b0001, 0, 0));
      idle();
      stop = 1'b1;
      cycle("final_stop", mk(0, 4'b0000, 4'b0001, 0, 0));
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
